// File: rtl/deserializer_fifo.sv
`default_nettype none
// ============================================================================
// Module   : deserializer_fifo
// Brief    : Serial-to-parallel word assembler feeding a DEPTH-entry output
//            FIFO, with occupancy and dropped-bit reporting.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module deserializer_fifo #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 2,
    parameter int MSB_FIRST = 1
) (
    input  logic                       clock_100KHZ,
    input  logic                       reset,
    input  logic                       data_in,
    input  logic                       write_in,
    input  logic                       ack_in,
    output logic                       status_out,
    output logic [WIDTH-1:0]           data_out,
    output logic                       data_ready,
    output logic [$clog2(DEPTH+1)-1:0] fill_out,
    output logic                       overflow_out
);

    localparam int CW = $clog2(WIDTH);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int FW = $clog2(DEPTH + 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [FW-1:0]    count_q, count_d;
    logic             status_q, status_d;
    logic             overflow_q, overflow_d;

    logic             accept;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] shifted;

    // Pointers wrap explicitly so non-power-of-two depths behave as a ring.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign shifted = {shreg_q[WIDTH-2:0], data_in};
        end else begin : g_lsb_first
            assign shifted = {data_in, shreg_q[WIDTH-1:1]};
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shreg_d    = shreg_q;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        push       = 1'b0;
        accept     = write_in & status_q;
        pop        = ack_in & (count_q != '0);
        overflow_d = write_in & ~status_q;

        if (accept) begin
            shreg_d = shifted;
            case (state_q)
                IDLE: begin
                    state_d = SHIFT;
                    cnt_d   = CW'(1);
                end
                SHIFT: begin
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        push    = 1'b1;
                        cnt_d   = '0;
                        shreg_d = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        if (push) begin
            mem_d[wr_ptr_q] = shifted;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + FW'(1);
            2'b01:   count_d = count_q - FW'(1);
            default: count_d = count_q;
        endcase

        // Only a push can fill the buffer, so readiness drops at word boundaries.
        status_d = (count_d < FW'(DEPTH));
    end

    always_ff @(posedge clock_100KHZ or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            shreg_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            status_q   <= 1'b0;
            overflow_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shreg_q    <= shreg_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            status_q   <= status_d;
            overflow_q <= overflow_d;
            mem_q      <= mem_d;
        end
    end

    assign status_out   = status_q;
    assign overflow_out = overflow_q;
    assign data_ready   = (count_q != '0);
    assign fill_out     = count_q;
    assign data_out     = (count_q != '0) ? mem_q[rd_ptr_q] : '0;

endmodule
`default_nettype wire

// File: tb/tb_deserializer_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_deserializer_fifo
// Brief    : Scenario bench for deserializer_fifo across bit orders and depths.
// Revision : 1.0 - initial release
// ============================================================================
module tb_deserializer_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       din [3];
    logic       wr  [3];
    logic       ack [3];
    logic       st  [3];
    logic       rdy [3];
    logic       ovf [3];
    logic [7:0] dout [3];
    logic [2:0] fl  [3];
    logic [1:0] fill_msb, fill_lsb;
    logic [2:0] fill_deep;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] sb0 [$];
    logic [7:0] sb2 [$];

    always #5 clk = ~clk;

    // 0: MSB-first depth 2, 1: LSB-first depth 2, 2: MSB-first depth 4
    deserializer_fifo #(.WIDTH(8), .DEPTH(2), .MSB_FIRST(1)) u_msb (
        .clock_100KHZ(clk), .reset(rst), .data_in(din[0]), .write_in(wr[0]),
        .ack_in(ack[0]), .status_out(st[0]), .data_out(dout[0]),
        .data_ready(rdy[0]), .fill_out(fill_msb), .overflow_out(ovf[0]));

    deserializer_fifo #(.WIDTH(8), .DEPTH(2), .MSB_FIRST(0)) u_lsb (
        .clock_100KHZ(clk), .reset(rst), .data_in(din[1]), .write_in(wr[1]),
        .ack_in(ack[1]), .status_out(st[1]), .data_out(dout[1]),
        .data_ready(rdy[1]), .fill_out(fill_lsb), .overflow_out(ovf[1]));

    deserializer_fifo #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1)) u_deep (
        .clock_100KHZ(clk), .reset(rst), .data_in(din[2]), .write_in(wr[2]),
        .ack_in(ack[2]), .status_out(st[2]), .data_out(dout[2]),
        .data_ready(rdy[2]), .fill_out(fill_deep), .overflow_out(ovf[2]));

    assign fl[0] = {1'b0, fill_msb};
    assign fl[1] = {1'b0, fill_lsb};
    assign fl[2] = fill_deep;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input int k, input logic b);
        wr[k]  = 1'b1;
        din[k] = b;
        tick();
        wr[k]  = 1'b0;
        din[k] = 1'b0;
    endtask

    task automatic send_word(input int k, input logic [7:0] w, input bit lsb_first);
        for (int i = 0; i < 8; i++) begin
            send_bit(k, lsb_first ? w[i] : w[7-i]);
        end
    endtask

    task automatic do_ack(input int k);
        ack[k] = 1'b1;
        tick();
        ack[k] = 1'b0;
    endtask

    task automatic test_reset();
        #23;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if ({st[k], rdy[k], ovf[k], dout[k], fl[k]} !== 14'd0) begin
                n_fail++;
                $display("FAIL reset_state[%0d]: got st=%b rdy=%b ovf=%b dout=%h fill=%0d, want all 0",
                         k, st[k], rdy[k], ovf[k], dout[k], fl[k]);
            end
        end
        rst = 1'b0;
        tick();
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (st[k] !== 1'b1) begin
                n_fail++;
                $display("FAIL status_after_reset[%0d]: got %b want 1", k, st[k]);
            end
        end
    endtask

    task automatic test_msb_first();
        logic [7:0] s;
        s = 8'b1011_0010;
        for (int i = 0; i < 7; i++) send_bit(0, s[7-i]);
        n_checks++;
        if (rdy[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL msb_partial_ready: got %b want 0", rdy[0]);
        end
        send_bit(0, s[0]);
        n_checks++;
        if (dout[0] !== 8'hB2 || rdy[0] !== 1'b1 || fl[0] !== 3'd1) begin
            n_fail++;
            $display("FAIL msb_word: got dout=%h rdy=%b fill=%0d want B2 1 1", dout[0], rdy[0], fl[0]);
        end
        do_ack(0);
        n_checks++;
        if (dout[0] !== 8'h00 || rdy[0] !== 1'b0 || fl[0] !== 3'd0) begin
            n_fail++;
            $display("FAIL msb_pop: got dout=%h rdy=%b fill=%0d want 00 0 0", dout[0], rdy[0], fl[0]);
        end
    endtask

    task automatic test_lsb_first();
        logic [7:0] s;
        s = 8'b1011_0010;
        for (int i = 0; i < 8; i++) send_bit(1, s[7-i]);
        n_checks++;
        if (dout[1] !== 8'h4D || rdy[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL lsb_word: got dout=%h rdy=%b want 4D 1", dout[1], rdy[1]);
        end
        do_ack(1);
        for (int i = 0; i < 8; i++) begin
            send_bit(1, s[7-i]);
            if (i != 7) begin
                for (int g = 0; g < 5; g++) begin
                    tick();
                    n_checks++;
                    if (st[1] !== 1'b1 || rdy[1] !== 1'b0) begin
                        n_fail++;
                        $display("FAIL lsb_gap_status: got st=%b rdy=%b want 1 0", st[1], rdy[1]);
                    end
                end
            end
        end
        n_checks++;
        if (dout[1] !== 8'h4D || fl[1] !== 3'd1) begin
            n_fail++;
            $display("FAIL lsb_gapped_word: got dout=%h fill=%0d want 4D 1", dout[1], fl[1]);
        end
        do_ack(1);
    endtask

    task automatic test_overflow();
        send_word(0, 8'hA5, 1'b0); sb0.push_back(8'hA5);
        send_word(0, 8'h3C, 1'b0); sb0.push_back(8'h3C);
        n_checks++;
        if (fl[0] !== 3'd2 || st[0] !== 1'b0 || dout[0] !== sb0[0]) begin
            n_fail++;
            $display("FAIL full_state: got fill=%0d st=%b dout=%h want 2 0 %h", fl[0], st[0], dout[0], sb0[0]);
        end
        send_bit(0, 1'b1);
        n_checks++;
        if (ovf[0] !== 1'b1 || fl[0] !== 3'd2) begin
            n_fail++;
            $display("FAIL overflow_pulse: got ovf=%b fill=%0d want 1 2", ovf[0], fl[0]);
        end
        tick();
        n_checks++;
        if (ovf[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow_width: got %b want 0", ovf[0]);
        end
        do_ack(0); void'(sb0.pop_front());
        n_checks++;
        if (dout[0] !== sb0[0] || st[0] !== 1'b1 || fl[0] !== 3'd1) begin
            n_fail++;
            $display("FAIL pop_from_full: got dout=%h st=%b fill=%0d want %h 1 1", dout[0], st[0], fl[0], sb0[0]);
        end
        do_ack(0); void'(sb0.pop_front());
        n_checks++;
        if (rdy[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_after_full: got rdy=%b want 0", rdy[0]);
        end
    endtask

    task automatic test_simultaneous();
        logic [7:0] w;
        w = 8'h22;
        send_word(0, 8'h11, 1'b0); sb0.push_back(8'h11);
        for (int i = 0; i < 7; i++) send_bit(0, w[7-i]);
        wr[0] = 1'b1; din[0] = w[0]; ack[0] = 1'b1;
        tick();
        wr[0] = 1'b0; din[0] = 1'b0; ack[0] = 1'b0;
        void'(sb0.pop_front()); sb0.push_back(w);
        n_checks++;
        if (fl[0] !== 3'd1 || dout[0] !== sb0[0]) begin
            n_fail++;
            $display("FAIL push_pop_same_edge: got fill=%0d dout=%h want 1 %h", fl[0], dout[0], sb0[0]);
        end
        do_ack(0); void'(sb0.pop_front());
    endtask

    task automatic test_reset_midword();
        for (int i = 0; i < 3; i++) send_bit(0, 1'b1);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({st[0], rdy[0], ovf[0], dout[0], fl[0]} !== 14'd0) begin
            n_fail++;
            $display("FAIL async_reset: got st=%b rdy=%b ovf=%b dout=%h fill=%0d want all 0",
                     st[0], rdy[0], ovf[0], dout[0], fl[0]);
        end
        tick();
        #3 rst = 1'b0;
        tick();
        n_checks++;
        if (st[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL status_after_midword_reset: got %b want 1", st[0]);
        end
        for (int i = 0; i < 7; i++) send_bit(0, 1'b1);
        n_checks++;
        if (rdy[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL residue_after_reset: got rdy=%b want 0 after 7 bits", rdy[0]);
        end
        send_bit(0, 1'b1);
        n_checks++;
        if (dout[0] !== 8'hFF || fl[0] !== 3'd1) begin
            n_fail++;
            $display("FAIL word_after_reset: got dout=%h fill=%0d want FF 1", dout[0], fl[0]);
        end
        do_ack(0);
    endtask

    task automatic test_empty_ack();
        do_ack(0);
        n_checks++;
        if (rdy[0] !== 1'b0 || fl[0] !== 3'd0 || st[0] !== 1'b1 || dout[0] !== 8'h00) begin
            n_fail++;
            $display("FAIL empty_ack: got rdy=%b fill=%0d st=%b dout=%h want 0 0 1 00",
                     rdy[0], fl[0], st[0], dout[0]);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] words [6];
        words = '{8'h01, 8'h9E, 8'h5A, 8'hC3, 8'h7F, 8'h80};
        for (int n = 0; n < 6; n++) begin
            send_word(2, words[n], 1'b0);
            sb2.push_back(words[n]);
            n_checks++;
            if (fl[2] !== 3'(sb2.size()) || fl[2] > 3'd4) begin
                n_fail++;
                $display("FAIL wrap_fill[%0d]: got %0d want %0d", n, fl[2], sb2.size());
            end
            if (n == 1 || n == 3) begin
                n_checks++;
                if (dout[2] !== sb2[0]) begin
                    n_fail++;
                    $display("FAIL wrap_mid_head[%0d]: got %h want %h", n, dout[2], sb2[0]);
                end
                do_ack(2); void'(sb2.pop_front());
            end
        end
        n_checks++;
        if (st[2] !== 1'b0 || fl[2] !== 3'd4) begin
            n_fail++;
            $display("FAIL deep_full: got st=%b fill=%0d want 0 4", st[2], fl[2]);
        end
        while (sb2.size() > 0) begin
            n_checks++;
            if (dout[2] !== sb2[0]) begin
                n_fail++;
                $display("FAIL wrap_drain_order: got %h want %h", dout[2], sb2[0]);
            end
            do_ack(2); void'(sb2.pop_front());
        end
        n_checks++;
        if (rdy[2] !== 1'b0 || st[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_empty: got rdy=%b st=%b want 0 1", rdy[2], st[2]);
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            din[k] = 1'b0;
            wr[k]  = 1'b0;
            ack[k] = 1'b0;
        end
        test_reset();
        test_msb_first();
        test_lsb_first();
        test_overflow();
        test_simultaneous();
        test_reset_midword();
        test_empty_ack();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
